// File: rtl/mem_pkg.sv
// Shared definitions for the byte-serial RAM arbiter: access sizes, FSM states, grant owner.
package mem_pkg;

    localparam int LANES = 4;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        GR_IF  = 1'b0,
        GR_LSB = 1'b1
    } grant_e;

    // Number of byte beats for an access size; the unused encoding 3 behaves as a word.
    function automatic logic [2:0] beat_count(input logic [1:0] size);
        case (size)
            SZ_B:    beat_count = 3'd1;
            SZ_H:    beat_count = 3'd2;
            default: beat_count = 3'(LANES);
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Inserts a captured RAM byte into its little-endian lane and extends the assembled result.
module mem_byte_lane
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word_i,
    input  logic [7:0]      byte_i,
    input  logic [1:0]      lane_i,
    input  logic [1:0]      size_i,
    input  logic            signed_i,
    output logic [XLEN-1:0] word_o,
    output logic [XLEN-1:0] ext_o
);

    // Drop the captured byte into lane lane_i, other lanes pass through.
    always_comb begin
        // NOTE: full default first so no path leaves word_o unassigned (no latch).
        word_o = word_i;
        word_o[{lane_i, 3'b000} +: 8] = byte_i;
    end

    // Zero/sign extend byte and half results; words pass unchanged.
    always_comb begin
        unique case (size_i)
            SZ_B:    ext_o = {{(XLEN-8){signed_i & word_o[7]}}, word_o[7:0]};
            SZ_H:    ext_o = {{(XLEN-16){signed_i & word_o[15]}}, word_o[15:0]};
            default: ext_o = word_o;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-wide RAM port sequencer shared by instruction fetch and the load/store buffer.
// Splits accesses into byte beats, assembles read data and alternates grants under contention.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [XLEN-1:0]   if_rdata,
    input  logic              lsb_req,
    input  logic              lsb_we,
    input  logic [1:0]        lsb_size,
    input  logic              lsb_signed,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [XLEN-1:0]   lsb_wdata,
    output logic              lsb_done,
    output logic [XLEN-1:0]   lsb_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_writing,
    output logic [7:0]        ram_data,
    input  logic [7:0]        ram_loaded_data
);

    arb_state_e        state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    grant_e            owner_q, owner_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   asm_q, asm_d;
    logic              if_done_q, if_done_d;
    logic              lsb_done_q, lsb_done_d;
    logic [XLEN-1:0]   if_rdata_q, if_rdata_d;
    logic [XLEN-1:0]   lsb_rdata_q, lsb_rdata_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_writing_q, ram_writing_d;
    logic [7:0]        ram_data_q, ram_data_d;

    logic [2:0]        beat_n;
    logic [2:0]        beat_nxt;
    logic [1:0]        cap_lane;
    logic              if_go;
    logic              pick_lsb;
    logic [XLEN-1:0]   lane_word;
    logic [XLEN-1:0]   lane_ext;

    // Beat k's byte arrives one cycle after its address, so at edge cnt_q+1 we capture byte cnt_q-1.
    assign beat_n   = beat_count(size_q);
    assign beat_nxt = cnt_q + 3'd1;
    assign cap_lane = 2'(cnt_q - 3'd1);
    assign if_go    = if_req & ~if_flush;

    mem_byte_lane #(.XLEN(XLEN)) u_lane (
        .word_i   (asm_q),
        .byte_i   (ram_loaded_data),
        .lane_i   (cap_lane),
        .size_i   (size_q),
        .signed_i (signed_q),
        .word_o   (lane_word),
        .ext_o    (lane_ext)
    );

    // Next-state and registered-output logic; DONE arbitrates like IDLE so its closing edge can accept.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        size_d        = size_q;
        signed_d      = signed_q;
        wdata_d       = wdata_q;
        asm_d         = asm_q;
        if_done_d     = 1'b0;
        lsb_done_d    = 1'b0;
        if_rdata_d    = if_rdata_q;
        lsb_rdata_d   = lsb_rdata_q;
        ram_addr_d    = ram_addr_q;
        ram_writing_d = ram_writing_q;
        ram_data_d    = ram_data_q;
        pick_lsb      = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (if_go || lsb_req) begin
                    pick_lsb = lsb_req && (!if_go || last_grant_q == GR_IF);
                    cnt_d    = '0;
                    asm_d    = '0;
                    if (pick_lsb) begin
                        last_grant_d = GR_LSB;
                        owner_d      = GR_LSB;
                        addr_d       = lsb_addr;
                        size_d       = lsb_size;
                        signed_d     = lsb_signed;
                        wdata_d      = lsb_wdata;
                        ram_addr_d   = lsb_addr;
                        if (lsb_we) begin
                            state_d       = ST_WRITE;
                            ram_writing_d = 1'b1;
                            ram_data_d    = lsb_wdata[7:0];
                        end else begin
                            state_d       = ST_READ;
                            ram_writing_d = 1'b0;
                        end
                    end else begin
                        last_grant_d  = GR_IF;
                        owner_d       = GR_IF;
                        addr_d        = if_addr;
                        size_d        = SZ_W;
                        signed_d      = 1'b0;
                        ram_addr_d    = if_addr;
                        ram_writing_d = 1'b0;
                        state_d       = ST_READ;
                    end
                end
            end

            ST_READ: begin
                if (owner_q == GR_IF && if_flush) begin
                    state_d    = ST_IDLE;
                    ram_addr_d = '0;
                end else begin
                    cnt_d = beat_nxt;
                    if (beat_nxt < beat_n) begin
                        ram_addr_d = addr_q + ADDR_W'(beat_nxt);
                    end
                    if (cnt_q != 3'd0) begin
                        asm_d = lane_word;
                    end
                    if (cnt_q == beat_n) begin
                        state_d = ST_DONE;
                        if (owner_q == GR_IF) begin
                            if_done_d  = 1'b1;
                            if_rdata_d = lane_ext;
                        end else begin
                            lsb_done_d  = 1'b1;
                            lsb_rdata_d = lane_ext;
                        end
                    end
                end
            end

            ST_WRITE: begin
                cnt_d = beat_nxt;
                if (beat_nxt < beat_n) begin
                    ram_addr_d = addr_q + ADDR_W'(beat_nxt);
                    ram_data_d = wdata_q[{beat_nxt[1:0], 3'b000} +: 8];
                end else begin
                    ram_writing_d = 1'b0;
                    lsb_done_d    = 1'b1;
                    state_d       = ST_DONE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= GR_IF;
            owner_q       <= GR_IF;
            cnt_q         <= '0;
            addr_q        <= '0;
            size_q        <= SZ_B;
            signed_q      <= 1'b0;
            wdata_q       <= '0;
            asm_q         <= '0;
            if_done_q     <= 1'b0;
            lsb_done_q    <= 1'b0;
            if_rdata_q    <= '0;
            lsb_rdata_q   <= '0;
            ram_addr_q    <= '0;
            ram_writing_q <= 1'b0;
            ram_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            size_q        <= size_d;
            signed_q      <= signed_d;
            wdata_q       <= wdata_d;
            asm_q         <= asm_d;
            if_done_q     <= if_done_d;
            lsb_done_q    <= lsb_done_d;
            if_rdata_q    <= if_rdata_d;
            lsb_rdata_q   <= lsb_rdata_d;
            ram_addr_q    <= ram_addr_d;
            ram_writing_q <= ram_writing_d;
            ram_data_q    <= ram_data_d;
        end
    end

    assign if_done     = if_done_q;
    assign if_rdata    = if_rdata_q;
    assign lsb_done    = lsb_done_q;
    assign lsb_rdata   = lsb_rdata_q;
    assign ram_addr    = ram_addr_q;
    assign ram_writing = ram_writing_q;
    assign ram_data    = ram_data_q;

endmodule
